// File: rtl/seg_pkg.sv
// Shared constants, segment codes and converter state type for the six-digit
// seven-segment scan driver.
package seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DATA_W     = 20;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int MAX_VAL    = 999_999;

    // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        CVT_IDLE  = 2'd0,
        CVT_SHIFT = 2'd1,
        CVT_DONE  = 2'd2
    } cvt_state_e;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_drv_if.sv
// Numeric display bus: value source drives it (master), scan driver reads it (slave).
interface seg_scan_drv_if;

    logic [seg_pkg::DATA_W-1:0]     data;
    logic [seg_pkg::NUM_DIGITS-1:0] point;
    logic                           en;
    logic                           sign;

    modport master (output data, point, en, sign);
    modport slave  (input  data, point, en, sign);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: IDLE snapshot, 20 add-3/shift cycles, DONE.
// Inputs above MAX_VAL are saturated so the result always fits six BCD digits.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] bin_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [BCD_W-1:0]  bcd_o
);

    localparam logic [4:0]        SHIFT_LAST = 5'(DATA_W - 1);
    localparam logic [DATA_W-1:0] SAT_VAL    = DATA_W'(MAX_VAL);

    cvt_state_e        state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  bcd_adj;
    logic [4:0]        cnt_q, cnt_d;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CVT_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CVT_IDLE: begin
                if (start_i) begin
                    bin_d   = (bin_i > SAT_VAL) ? SAT_VAL : bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CVT_SHIFT;
                end
            end
            CVT_SHIFT: begin
                // Adjust every nibble first, then shift the whole BCD:binary pair left.
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == SHIFT_LAST) begin
                    state_d = CVT_DONE;
                end
            end
            CVT_DONE: begin
                state_d = CVT_IDLE;
            end
            default: begin
                state_d = CVT_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != CVT_IDLE);
    assign done_o = (state_q == CVT_DONE);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_drv.sv
// Six-digit common-anode scan driver: free-running BCD conversion, frame-locked
// buffers, leading-zero blanking and sign placement (enabled by SEG_LZB_EN).
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50_000
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_drv_if.slave         disp,
    output logic [NUM_DIGITS-1:0] seg_sel,
    output logic [7:0]            seg_led
);

    localparam int         DIV_W    = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_q, div_d;
    logic [2:0]            idx_q, idx_d;
    logic                  sign_snap_q, sign_snap_d;
    logic [BCD_W-1:0]      pend_bcd_q, pend_bcd_d;
    logic                  pend_sign_q, pend_sign_d;
    logic [BCD_W-1:0]      shown_bcd_q, shown_bcd_d;
    logic                  shown_sign_q, shown_sign_d;
    logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
    logic [7:0]            seg_led_q, seg_led_d;

    logic                  div_tc;
    logic                  frame_wrap;
    logic                  cvt_busy;
    logic                  cvt_done;
    logic [BCD_W-1:0]      cvt_bcd;

    logic [NUM_DIGITS-1:0] digit_nz;
    logic [NUM_DIGITS-1:0] digit_lit;
    logic [NUM_DIGITS-1:0] digit_minus;
    logic [7:0]            digit_code [NUM_DIGITS];
    logic [7:0]            cur_code;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (1'b1),
        .bin_i   (disp.data),
        .busy_o  (cvt_busy),
        .done_o  (cvt_done),
        .bcd_o   (cvt_bcd)
    );

    assign div_tc     = (div_q == DIV_LAST);
    assign frame_wrap = div_tc && (idx_q == IDX_LAST);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_tc) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // The sign is captured on the same edge the converter captures data.
    always_comb begin
        sign_snap_d  = cvt_busy ? sign_snap_q : disp.sign;
        pend_bcd_d   = pend_bcd_q;
        pend_sign_d  = pend_sign_q;
        shown_bcd_d  = shown_bcd_q;
        shown_sign_d = shown_sign_q;
        if (cvt_done) begin
            pend_bcd_d  = cvt_bcd;
            pend_sign_d = sign_snap_q;
        end
        // Reads the old pending value, so a same-edge DONE lands one frame later.
        if (frame_wrap) begin
            shown_bcd_d  = pend_bcd_q;
            shown_sign_d = pend_sign_q;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_nz[gi] = |shown_bcd_q[gi*4 +: 4];
`ifdef SEG_LZB_EN
        if (gi == 0) begin : g_lsd
            assign digit_lit[gi]   = 1'b1;
            assign digit_minus[gi] = 1'b0;
        end else begin : g_upper
            assign digit_lit[gi]   = |digit_nz[NUM_DIGITS-1:gi];
            assign digit_minus[gi] = shown_sign_q & ~digit_lit[gi] & digit_lit[gi-1];
        end
`else
        assign digit_lit[gi] = 1'b1;
        if (gi == NUM_DIGITS - 1) begin : g_msd
            assign digit_minus[gi] = shown_sign_q & ~digit_nz[gi];
        end else begin : g_lower
            assign digit_minus[gi] = 1'b0;
        end
`endif
        assign digit_code[gi] = digit_minus[gi] ? SEG_MINUS :
                                digit_lit[gi]   ? seg_decode(shown_bcd_q[gi*4 +: 4]) :
                                                  SEG_BLANK;
    end

    assign cur_code = digit_code[idx_q];

    always_comb begin
        seg_sel_d = '1;
        seg_led_d = SEG_BLANK;
        if (disp.en) begin
            seg_sel_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_led_d = {cur_code[7] & ~disp.point[idx_q], cur_code[6:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            sign_snap_q  <= 1'b0;
            pend_bcd_q   <= '0;
            pend_sign_q  <= 1'b0;
            shown_bcd_q  <= '0;
            shown_sign_q <= 1'b0;
            seg_sel_q    <= '1;
            seg_led_q    <= SEG_BLANK;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            sign_snap_q  <= sign_snap_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_sign_q  <= pend_sign_d;
            shown_bcd_q  <= shown_bcd_d;
            shown_sign_q <= shown_sign_d;
            seg_sel_q    <= seg_sel_d;
            seg_led_q    <= seg_led_d;
        end
    end

    assign seg_sel = seg_sel_q;
    assign seg_led = seg_led_q;

endmodule
